// File: rtl/led_probe_scanner_if.sv
// Board-side link between led_probe_scanner and the core's debug readout port,
// plus the scanner's UART line and status flags.
interface led_probe_scanner_if;
  // en is a level request sampled on every clock; busy stays high from the first
  // edge that sees en in IDLE until the scanner has re-entered IDLE, so a requester
  // may drop en at any time and watch busy to know when the entry in flight is done.
  logic        en;
  logic [11:0] led;
  logic [7:0]  led_sel;
  logic        tx;
  logic        busy;
  logic        sweep_done;
  logic [2:0]  dbg_state;

  modport master (
    input  en,
    input  led,
    output led_sel,
    output tx,
    output busy,
    output sweep_done,
    output dbg_state
  );

  modport slave (
    output en,
    output led,
    input  led_sel,
    input  tx,
    input  busy,
    input  sweep_done,
    input  dbg_state
  );
endinterface

// File: rtl/led_probe_scanner.sv
// Sweeps led_sel over [SEL_FIRST, SEL_LAST], captures the settled led readout and
// ships each entry as a 4-byte UART 8N1 frame (A5, sel, led[11:8], led[7:0]) on tx.
module led_probe_scanner #(
  parameter int SEL_FIRST = 0,
  parameter int SEL_LAST  = 31,
  parameter int SETTLE    = 4,
  parameter int BAUD_DIV  = 16
) (
  input logic           clk,
  input logic           rst,
  led_probe_scanner_if.master bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_NEXT    = 3'd4;

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int BW = $clog2(BAUD_DIV);

  localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE - 1);
  localparam logic [BW-1:0] BAUD_END   = BW'(BAUD_DIV - 1);
  localparam logic [7:0]    SEL_LO     = 8'(SEL_FIRST);
  localparam logic [7:0]    SEL_HI     = 8'(SEL_LAST);
  localparam logic [7:0]    SYNC_BYTE  = 8'hA5;

  logic [2:0]    state_q,  state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [BW-1:0] baud_q,   baud_d;
  logic [3:0]    bit_q,    bit_d;
  logic [1:0]    byte_q,   byte_d;
  logic [7:0]    sel_q,    sel_d;
  logic [7:0]    cap_sel_q, cap_sel_d;
  logic [11:0]   cap_led_q, cap_led_d;
  logic          tx_q,     tx_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;

  logic [7:0]    cur_byte;
  logic          cur_bit;

  // Bit position 0 is the start bit, 1..8 the data bits LSB first, 9 the stop bit.
  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_q)
      2'd1:    cur_byte = cap_sel_q;
      2'd2:    cur_byte = {4'h0, cap_led_q[11:8]};
      2'd3:    cur_byte = cap_led_q[7:0];
      default: cur_byte = SYNC_BYTE;
    endcase

    if (bit_q == 4'd0) begin
      cur_bit = 1'b0;
    end else if (bit_q >= 4'd9) begin
      cur_bit = 1'b1;
    end else begin
      cur_bit = cur_byte[3'(bit_q - 4'd1)];
    end
  end

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    sel_d     = sel_q;
    cap_sel_d = cap_sel_q;
    cap_led_d = cap_led_q;
    tx_d      = 1'b1;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end

      ST_SETTLE: begin
        if (settle_q == SETTLE_END) begin
          state_d = ST_CAPTURE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      ST_CAPTURE: begin
        cap_led_d = bus.led;
        cap_sel_d = sel_q;
        byte_d    = 2'd0;
        bit_d     = 4'd0;
        baud_d    = '0;
        state_d   = ST_SEND;
      end

      // tx is registered, so the line lags the counters by one cycle; the stop bit
      // of the last byte therefore overlaps the NEXT cycle.
      ST_SEND: begin
        tx_d = cur_bit;
        if (baud_q == BAUD_END) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            bit_d = 4'd0;
            if (byte_q == 2'd3) begin
              state_d = ST_NEXT;
            end else begin
              byte_d = byte_q + 2'd1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_NEXT: begin
        if (sel_q == SEL_HI) begin
          sel_d  = SEL_LO;
          done_d = 1'b1;
        end else begin
          sel_d = sel_q + 8'd1;
        end
        settle_d = '0;
        state_d  = bus.en ? ST_SETTLE : ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      baud_q    <= '0;
      bit_q     <= 4'd0;
      byte_q    <= 2'd0;
      sel_q     <= SEL_LO;
      cap_sel_q <= 8'd0;
      cap_led_q <= 12'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      sel_q     <= sel_d;
      cap_sel_q <= cap_sel_d;
      cap_led_q <= cap_led_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.led_sel    = sel_q;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = done_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: doc/led_probe_scanner.md
Name: led_probe_scanner

Overview:
- Reads the `top` debug readout port from the other end: drives `led_sel`, waits for the readout to settle, and captures the 12-bit `led` value.
- Serialises each captured entry as a 4-byte UART 8N1 frame on `tx` for host-side logging.
- Sweeps a configurable select range continuously while enabled.
- Sits outside `top` on the board wrapper, clocked by the same `clk` as the core.

Parameters:
- SEL_FIRST, 0, first `led_sel` value of a sweep (0..255).
- SEL_LAST, 31, last `led_sel` value of a sweep; must be >= SEL_FIRST.
- SETTLE, 4, clk cycles `led_sel` is held stable before `led` is captured; minimum 1.
- BAUD_DIV, 16, clk cycles per UART bit; minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  sweep enable, level-sensitive.
- led  in  12  readout data from `top`.
- led_sel  out  8  readout select to `top`.
- tx  out  1  UART serial output, idle high.
- busy  out  1  high from leaving IDLE until return to IDLE.
- sweep_done  out  1  one-cycle pulse after the SEL_LAST frame's stop bit ends.

Behaviour:
- Reset (rst=0, asynchronous): `led_sel`=SEL_FIRST, `tx`=1, `busy`=0, `sweep_done`=0, state=IDLE, all counters 0, capture register 0. Asserting reset mid-frame forces `tx`=1 immediately, without waiting for a clock edge.
- States: IDLE, SETTLE, CAPTURE, SEND, NEXT.
- IDLE:
  - `tx`=1, `busy`=0.
  - On an edge with en=1, go to SETTLE with settle counter=0. `led_sel` is not changed.
- SETTLE: counts SETTLE cycles, then goes to CAPTURE. `led_sel` is stable throughout.
- CAPTURE: one cycle. Registers `led` and the current `led_sel`, loads byte index 0, then goes to SEND.
- SEND:
  - Transmits 4 bytes back to back: byte0=8'hA5 (sync), byte1=sel, byte2={4'h0, led[11:8]}, byte3=led[7:0].
  - Each byte is: start bit 0, 8 data bits LSB first, stop bit 1, i.e. 10 bits.
  - Every bit is held exactly BAUD_DIV cycles.
  - No idle gap between bytes; a frame is 40*BAUD_DIV cycles.
- Latency: the first `tx` falling edge (byte0 start bit) is driven in the cycle SETTLE+2 edges after the edge that sampled en=1 in IDLE.
- NEXT: one cycle.
  - If `led_sel`==SEL_LAST: `led_sel`=SEL_FIRST and `sweep_done`=1 for this cycle only.
  - Otherwise `led_sel` increments by 1. 8-bit arithmetic; wrap-around to SEL_FIRST, never past 255.
  - Then: if en=1, go to SETTLE; else go to IDLE.
- `en` deasserted mid-entry (SETTLE/CAPTURE/SEND): the current frame completes in full, `led_sel` advances in NEXT, then IDLE. No frame is ever truncated except by reset.
- Re-enable in IDLE resumes at the held `led_sel`; the sweep does not restart from SEL_FIRST.
- SEL_FIRST==SEL_LAST: `led_sel` is constant, and `sweep_done` pulses after every frame.
- `led` changing during SEND has no effect; the frame uses the value captured in CAPTURE.
- `busy` is 1 in SETTLE, CAPTURE, SEND and NEXT.

Test Plan:
- Reset check: hold rst=0 with en=1 and toggle clk -> `tx`=1, `led_sel`=0, `busy`=0, `sweep_done`=0. Assert rst=0 mid-byte -> `tx`=1 with no clock edge.
- Single frame: defaults, led=12'hABC, en=1 for one frame.
  - Bench UART decoder (BAUD_DIV=16) receives A5, 00, 0A, BC.
  - First start bit begins 6 cycles after the enabling edge.
  - Each bit lasts 16 cycles; frame lasts 640 cycles.
- Full sweep: SEL_FIRST=2, SEL_LAST=4, led=`led_sel`*3, en=1 held.
  - Frames carry (sel, data): (02, 006), (03, 009), (04, 00C), then (02, 006) again.
  - `sweep_done` pulses exactly once per sweep, one cycle, after the 04 frame.
- Enable drop mid-frame: clear en during byte1 of the sel=05 frame.
  - All 4 bytes still sent; `led_sel`=06; `busy` falls.
  - Re-enable -> next frame has sel byte 06.
- Capture isolation: change `led` from 12'h123 to 12'hFFF during byte2 -> frame still carries 01, 23.
- Wrap and boundary: SEL_FIRST=SEL_LAST=255 -> `led_sel` stays FF, `sweep_done` pulses after every frame, no increment past 8'hFF.
